dec_trig_csr: RTL and testbench
===============================

# dec_trig_csr

Trigger CSR bank for four RV64 mcontrol triggers, located in the TLU. Holds tselect, tdata1 and tdata2 for each trigger. Services CSR reads and writes and enforces debug-mode (dmode) write locking. Records hit bits from committed trigger matches and drives the trigger_pkt_any packet that the decode-stage and LSU trigger comparators consume.

## Interface
Parameters:
- NTRIG, 4, number of triggers; fixed at 4, with the select index 2 bits wide.

Ports:
- clk  input  1  core clock
- rst_l  input  1  reset; asynchronous, active-low
- dbg_mode  input  1  core is in debug mode
- csr_wr_valid  input  1  CSR write strobe, single cycle
- csr_wr_addr  input  12  write address: 0x7A0 tselect, 0x7A1 tdata1, 0x7A2 tdata2
- csr_wr_data  input  64  write data
- csr_rd_valid  input  1  CSR read request
- csr_rd_addr  input  12  read address, same map as the write address
- csr_rd_data  output  64  read data, registered
- csr_rd_ack  output  1  read data valid
- trig_hit  input  4  committed trigger hits, one bit per trigger
- trigger_pkt_any  output  trigger_pkt_t[3:0]  per trigger: select, match, store, load, execute, m, tdata2[63:0]
- trigger_chain  output  2  bit 0 chains triggers 0/1; bit 1 chains triggers 2/3

## Operation
- tselect: 2-bit register. A write with csr_wr_data[63:2]≠0 is ignored. Reads return the value zero-extended.
- tdata1 read image for trigger i:
  - [63:60]=4'h2, [59]=dmode, [58:53]=6'h1F
  - [20]=hit, [19]=select, [18]=0, [17:12]=action, [11]=chain, [10:7]=match, [6]=m
  - [2]=execute, [1]=store, [0]=load; all other bits 0
- tdata1 write, applied to the trigger named by tselect:
  - If that trigger's dmode=1 and dbg_mode=0, the whole write is dropped.
  - dmode is written only when dbg_mode=1; otherwise it keeps its value.
  - action (WARL): 0 or 1 is stored. action=1 is stored only if the resulting dmode=1. Any other value stores 0.
  - match (WARL): 0 (equal) or 1 (NAPOT mask) is stored. Any other value stores 0.
  - chain: writable on triggers 0 and 2 only (see Configuration). Reads as 0 on triggers 1 and 3.
  - hit, select, m, execute, store, load: stored as written.
- tdata2 write: the full 64 bits are stored. The same dmode lock as tdata1 applies.
- Writes to any other address are ignored. Reads of any other address return 0 with csr_rd_ack=1.
- Hit capture: trig_hit[i]=1 sets hit[i]. hit is sticky and cleared only by a tdata1 write of bit 20 = 0.
- Packet drive:
  - select, match[0], m and tdata2 come straight from the registers.
  - execute, store and load are each ANDed with ~dbg_mode, so no trigger fires in debug mode.
- trigger_chain[k] = chain bit of trigger 2k.

## Timing
- Reset values:
  - tselect=0.
  - All dmode, hit, select, action, chain, match, m, execute, store, load = 0.
  - tdata2=0.
  - trigger_pkt_any all zero; trigger_chain=0.
  - csr_rd_data=0, csr_rd_ack=0.
- A CSR write at edge N is visible on trigger_pkt_any, and to a read issued in cycle N+1, after edge N.
- Read latency is 1 cycle: request in cycle N gives csr_rd_data and csr_rd_ack=1 in cycle N+1. Back-to-back reads are supported at one per cycle.
- A read and a write to the same CSR in the same cycle return the old value.
- trig_hit in cycle N sets hit at edge N.
- If trig_hit[i] and a tdata1 write to trigger i land in the same cycle, the written hit value wins.
- The dmode lock is evaluated on the register value before the edge, not on the incoming data.
- dbg_mode gating of the packet is combinational, with no extra latency.
- Reset asserted mid-operation clears all state immediately. Any pending read ack is lost.

## Configuration
- DEC_TRIG_CHAIN_EN defined:
  - tdata1[11] is writable on triggers 0 and 2.
  - trigger_chain is driven from those bits.
- DEC_TRIG_CHAIN_EN undefined:
  - chain reads 0 on all triggers and writes to it are ignored.
  - trigger_chain is tied to 2'b00.

## Test plan
- Reset, then read 0x7A1 with tselect=0 → csr_rd_data=0x2000_0000_0000_0000 | (0x1F<<53), csr_rd_ack=1 one cycle later.
- tselect=2, write tdata1=0x44 (m, execute) and tdata2=0x8000_1000 → trigger_pkt_any[2].execute=1, m=1, tdata2=0x8000_1000; with dbg_mode=1, execute=0.
- In debug mode, write tdata1 of trigger 1 with dmode=1 and action=1. Leave debug mode, then write tdata1=0 → write dropped; readback still shows dmode=1, action=1.
- Write action=5, match=3 → readback action=0, match=0. Write action=1 with dmode=0 outside debug mode → action=0.
- trig_hit=4'b1000 → trigger 3 hit=1 and stays set. In the same cycle as trig_hit[3], a tdata1 write with bit 20=0 → hit=0.
- Chain: write tdata1[11]=1 on triggers 0 and 1 → with DEC_TRIG_CHAIN_EN, trigger_chain=2'b01 and trigger 1 reads chain=0; without the macro, trigger_chain=0.

Source files
------------

// File: rtl/dec_trig_csr.sv
//----------------------------------------------------------------------------
// dec_trig_csr
//
// Trigger CSR bank for four RV64 mcontrol triggers in the TLU. Holds
// tselect plus tdata1/tdata2 per trigger, services CSR reads and writes,
// applies the dmode write lock, records committed trigger hits and drives
// the trigger packet consumed by the decode and LSU comparators.
//
// Ports:
//   clk              core clock
//   rst_l            asynchronous active-low reset
//   dbg_mode         core is in debug mode
//   csr_wr_valid     single-cycle CSR write strobe
//   csr_wr_addr      write address (0x7A0 tselect, 0x7A1 tdata1, 0x7A2 tdata2)
//   csr_wr_data      write data
//   csr_rd_valid     CSR read request
//   csr_rd_addr      read address, same map as writes
//   csr_rd_data      registered read data (one cycle after the request)
//   csr_rd_ack       read data valid
//   trig_hit         committed trigger hits, one bit per trigger
//   trigger_pkt_any  per-trigger packet for the comparators
//   trigger_chain    bit 0 chains triggers 0/1, bit 1 chains triggers 2/3
//
// Build option:
//   DEC_TRIG_CHAIN_EN  when defined, tdata1[11] (chain) is writable on
//                      triggers 0 and 2 and drives trigger_chain; otherwise
//                      chain reads 0 everywhere and trigger_chain is 0.
//----------------------------------------------------------------------------

package dec_trig_pkg;
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [63:0] tdata2;
    } trigger_pkt_t;
endpackage

module dec_trig_csr #(
    parameter int NTRIG = 4
) (
    input  logic                            clk,
    input  logic                            rst_l,
    input  logic                            dbg_mode,
    input  logic                            csr_wr_valid,
    input  logic [11:0]                     csr_wr_addr,
    input  logic [63:0]                     csr_wr_data,
    input  logic                            csr_rd_valid,
    input  logic [11:0]                     csr_rd_addr,
    output logic [63:0]                     csr_rd_data,
    output logic                            csr_rd_ack,
    input  logic [NTRIG-1:0]                trig_hit,
    output dec_trig_pkg::trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
    output logic [1:0]                      trigger_chain
);

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;

    logic [1:0]       tsel_q;
    logic [NTRIG-1:0] dmode_q;
    logic [NTRIG-1:0] hit_q;
    logic [NTRIG-1:0] select_q;
    logic [NTRIG-1:0] action_q;
    logic [NTRIG-1:0] chain_q;
    logic [NTRIG-1:0] match_q;
    logic [NTRIG-1:0] m_q;
    logic [NTRIG-1:0] execute_q;
    logic [NTRIG-1:0] store_q;
    logic [NTRIG-1:0] load_q;
    logic [63:0]      tdata2_q [NTRIG];

    logic        wr_tsel;
    logic        wr_td1;
    logic        wr_td2;
    logic        sel_locked;
    logic        new_dmode;
    logic        new_action;
    logic        new_match;
    logic        new_chain;
    logic [63:0] rd_img;

    assign wr_tsel = csr_wr_valid && (csr_wr_addr == ADDR_TSELECT);
    assign wr_td1  = csr_wr_valid && (csr_wr_addr == ADDR_TDATA1);
    assign wr_td2  = csr_wr_valid && (csr_wr_addr == ADDR_TDATA2);

    // Lock looks at the stored dmode of the selected trigger, never the
    // incoming data, so a locked trigger cannot unlock itself.
    assign sel_locked = dmode_q[tsel_q] & ~dbg_mode;

    always_comb begin
        new_dmode  = dbg_mode ? csr_wr_data[59] : dmode_q[tsel_q];
        // WARL: only 0/1 are legal; action=1 (enter debug) needs dmode=1.
        new_action = (csr_wr_data[17:12] == 6'd1) && new_dmode;
        new_match  = (csr_wr_data[10:7] == 4'd1);
`ifdef DEC_TRIG_CHAIN_EN
        new_chain  = csr_wr_data[11] & ~tsel_q[0];
`else
        new_chain  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tsel_q    <= '0;
            dmode_q   <= '0;
            hit_q     <= '0;
            select_q  <= '0;
            action_q  <= '0;
            match_q   <= '0;
            m_q       <= '0;
            execute_q <= '0;
            store_q   <= '0;
            load_q    <= '0;
            for (int i = 0; i < NTRIG; i++) begin
                tdata2_q[i] <= '0;
            end
        end else begin
            if (wr_tsel && (csr_wr_data[63:2] == 62'd0)) begin
                tsel_q <= csr_wr_data[1:0];
            end
            for (int i = 0; i < NTRIG; i++) begin
                if (trig_hit[i]) begin
                    hit_q[i] <= 1'b1;
                end
                // Written hit value overrides a same-cycle hit capture.
                if (wr_td1 && !sel_locked && (tsel_q == i[1:0])) begin
                    dmode_q[i]   <= new_dmode;
                    hit_q[i]     <= csr_wr_data[20];
                    select_q[i]  <= csr_wr_data[19];
                    action_q[i]  <= new_action;
                    match_q[i]   <= new_match;
                    m_q[i]       <= csr_wr_data[6];
                    execute_q[i] <= csr_wr_data[2];
                    store_q[i]   <= csr_wr_data[1];
                    load_q[i]    <= csr_wr_data[0];
                end
                if (wr_td2 && !sel_locked && (tsel_q == i[1:0])) begin
                    tdata2_q[i] <= csr_wr_data;
                end
            end
        end
    end

`ifdef DEC_TRIG_CHAIN_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            chain_q <= '0;
        end else if (wr_td1 && !sel_locked) begin
            for (int i = 0; i < NTRIG; i++) begin
                if (tsel_q == i[1:0]) begin
                    chain_q[i] <= new_chain;
                end
            end
        end
    end
`else
    assign chain_q = '0;
`endif

    always_comb begin
        rd_img = '0;
        case (csr_rd_addr)
            ADDR_TSELECT: rd_img = {62'd0, tsel_q};
            ADDR_TDATA1: rd_img = {4'h2, dmode_q[tsel_q], 6'h1F, 32'd0,
                                   hit_q[tsel_q], select_q[tsel_q], 1'b0,
                                   5'd0, action_q[tsel_q],
                                   chain_q[tsel_q],
                                   3'd0, match_q[tsel_q],
                                   m_q[tsel_q], 3'd0,
                                   execute_q[tsel_q], store_q[tsel_q],
                                   load_q[tsel_q]};
            ADDR_TDATA2: rd_img = tdata2_q[tsel_q];
            default:     rd_img = '0;
        endcase
    end

    // Reads sample the pre-edge registers, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            csr_rd_data <= '0;
            csr_rd_ack  <= 1'b0;
        end else begin
            csr_rd_ack <= csr_rd_valid;
            if (csr_rd_valid) begin
                csr_rd_data <= rd_img;
            end
        end
    end

    // Debug-mode gating is combinational so no trigger can fire while halted.
    always_comb begin
        for (int i = 0; i < NTRIG; i++) begin
            trigger_pkt_any[i].select  = select_q[i];
            trigger_pkt_any[i].match   = match_q[i];
            trigger_pkt_any[i].store   = store_q[i] & ~dbg_mode;
            trigger_pkt_any[i].load    = load_q[i] & ~dbg_mode;
            trigger_pkt_any[i].execute = execute_q[i] & ~dbg_mode;
            trigger_pkt_any[i].m       = m_q[i];
            trigger_pkt_any[i].tdata2  = tdata2_q[i];
        end
    end

    assign trigger_chain = {chain_q[2], chain_q[0]};

endmodule

// File: tb/tb_dec_trig_csr.sv
module tb_dec_trig_csr;
    import dec_trig_pkg::*;

`ifdef DEC_TRIG_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_l;
    logic         dbg_mode;
    logic         csr_wr_valid;
    logic [11:0]  csr_wr_addr;
    logic [63:0]  csr_wr_data;
    logic         csr_rd_valid;
    logic [11:0]  csr_rd_addr;
    logic [63:0]  csr_rd_data;
    logic         csr_rd_ack;
    logic [3:0]   trig_hit;
    trigger_pkt_t [3:0] trigger_pkt_any;
    logic [1:0]   trigger_chain;

    int checks = 0;
    int errors = 0;

    // Reference model: the architectural tdata1 read image per trigger.
    logic [63:0] m_img [4];
    logic [63:0] m_td2 [4];
    logic [1:0]  m_tsel;

    dec_trig_csr dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .dbg_mode        (dbg_mode),
        .csr_wr_valid    (csr_wr_valid),
        .csr_wr_addr     (csr_wr_addr),
        .csr_wr_data     (csr_wr_data),
        .csr_rd_valid    (csr_rd_valid),
        .csr_rd_addr     (csr_rd_addr),
        .csr_rd_data     (csr_rd_data),
        .csr_rd_ack      (csr_rd_ack),
        .trig_hit        (trig_hit),
        .trigger_pkt_any (trigger_pkt_any),
        .trigger_chain   (trigger_chain)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] build(input logic dm, input logic ht, input logic sl,
                                          input logic ac, input logic ch, input logic mt,
                                          input logic mm, input logic ex, input logic st,
                                          input logic ld);
        logic [63:0] v;
        v = (64'h2 << 60) + (64'h1F << 53);
        v = v + (64'(dm) << 59) + (64'(ht) << 20) + (64'(sl) << 19);
        v = v + (64'(ac) << 12) + (64'(ch) << 11) + (64'(mt) << 7) + (64'(mm) << 6);
        v = v + (64'(ex) << 2) + (64'(st) << 1) + 64'(ld);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_img[i] = build(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            m_td2[i] = 64'd0;
        end
        m_tsel = 2'd0;
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        case (a)
            12'h7A0: return {62'd0, m_tsel};
            12'h7A1: return m_img[m_tsel];
            12'h7A2: return m_td2[m_tsel];
            default: return 64'd0;
        endcase
    endfunction

    // Applies one clock edge worth of architectural effects to the model.
    task automatic model_edge();
        logic [63:0] wd;
        logic        nd;
        logic        locked;
        int          t;
        wd = csr_wr_data;
        t = int'(m_tsel);
        for (int i = 0; i < 4; i++) if (trig_hit[i]) m_img[i][20] = 1'b1;
        locked = m_img[t][59] && !dbg_mode;
        if (csr_wr_valid) begin
            if (csr_wr_addr == 12'h7A0) begin
                if ((wd >> 2) == 64'd0) m_tsel = wd[1:0];
            end else if (csr_wr_addr == 12'h7A1 && !locked) begin
                nd = dbg_mode ? wd[59] : m_img[t][59];
                m_img[t] = build(nd, wd[20], wd[19], (wd[17:12] == 6'd1) && nd,
                                 CHAIN_EN && (t % 2 == 0) && wd[11],
                                 wd[10:7] == 4'd1, wd[6], wd[2], wd[1], wd[0]);
            end else if (csr_wr_addr == 12'h7A2 && !locked) begin
                m_td2[t] = wd;
            end
        end
    endtask

    task automatic check_pkt();
        trigger_pkt_t e;
        for (int i = 0; i < 4; i++) begin
            e.select  = m_img[i][19];
            e.match   = m_img[i][7];
            e.store   = m_img[i][1] & ~dbg_mode;
            e.load    = m_img[i][0] & ~dbg_mode;
            e.execute = m_img[i][2] & ~dbg_mode;
            e.m       = m_img[i][6];
            e.tdata2  = m_td2[i];
            chk($sformatf("pkt%0d", i), 128'(trigger_pkt_any[i]), 128'(e));
        end
        chk("chain", 128'(trigger_chain), 128'({m_img[2][11], m_img[0][11]}));
    endtask

    // One clock: predict read, advance model, check outputs #1 after the edge.
    task automatic cycle();
        logic        rv;
        logic [63:0] rexp;
        rv = csr_rd_valid;
        rexp = model_read(csr_rd_addr);
        model_edge();
        @(posedge clk);
        #1;
        chk("rd_ack", 128'(csr_rd_ack), 128'(rv));
        if (rv) chk("rd_data", 128'(csr_rd_data), 128'(rexp));
        check_pkt();
        csr_wr_valid = 1'b0;
        csr_rd_valid = 1'b0;
        trig_hit     = 4'd0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = a;
        csr_wr_data  = d;
        cycle();
    endtask

    task automatic rd(input logic [11:0] a);
        csr_rd_valid = 1'b1;
        csr_rd_addr  = a;
        cycle();
    endtask

    function automatic logic [11:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 12'h7A0;
        if (r < 6) return 12'h7A1;
        if (r < 8) return 12'h7A2;
        if (r == 8) return 12'h7A3;
        return 12'($urandom);
    endfunction

    initial begin
        logic [63:0] d;
        rst_l        = 1'b0;
        dbg_mode     = 1'b0;
        csr_wr_valid = 1'b0;
        csr_wr_addr  = '0;
        csr_wr_data  = '0;
        csr_rd_valid = 1'b0;
        csr_rd_addr  = '0;
        trig_hit     = '0;
        model_reset();
        #12;
        chk("reset_rd_data", 128'(csr_rd_data), 128'(0));
        chk("reset_rd_ack", 128'(csr_rd_ack), 128'(0));
        check_pkt();
        rst_l = 1'b1;
        @(posedge clk);
        #1;

        // Reset image of tdata1.
        rd(12'h7A1);
        chk("reset_td1_const", 128'(csr_rd_data), 128'(64'h23E0_0000_0000_0000));

        // Trigger 2 execute with tdata2, then debug-mode gating.
        wr(12'h7A0, 64'd2);
        wr(12'h7A1, 64'h44);
        wr(12'h7A2, 64'h8000_1000);
        chk("t2_exec", 128'(trigger_pkt_any[2].execute), 128'(1));
        chk("t2_m", 128'(trigger_pkt_any[2].m), 128'(1));
        chk("t2_tdata2", 128'(trigger_pkt_any[2].tdata2), 128'(64'h8000_1000));
        dbg_mode = 1'b1;
        #1;
        chk("t2_exec_dbg", 128'(trigger_pkt_any[2].execute), 128'(0));
        check_pkt();

        // dmode lock on trigger 1.
        wr(12'h7A0, 64'd1);
        wr(12'h7A1, (64'd1 << 59) | (64'd1 << 12));
        dbg_mode = 1'b0;
        wr(12'h7A1, 64'd0);
        wr(12'h7A2, 64'hDEAD);
        rd(12'h7A1);
        chk("lock_dmode", 128'(csr_rd_data[59]), 128'(1));
        chk("lock_action", 128'(csr_rd_data[17:12]), 128'(1));
        rd(12'h7A2);
        chk("lock_td2", 128'(csr_rd_data), 128'(0));

        // WARL fields on trigger 0.
        wr(12'h7A0, 64'd0);
        wr(12'h7A1, (64'd5 << 12) | (64'd3 << 7));
        rd(12'h7A1);
        chk("warl_action5", 128'(csr_rd_data[17:12]), 128'(0));
        chk("warl_match3", 128'(csr_rd_data[10:7]), 128'(0));
        wr(12'h7A1, 64'd1 << 12);
        rd(12'h7A1);
        chk("warl_action_nodmode", 128'(csr_rd_data[17:12]), 128'(0));

        // Ignored tselect write and read of an unmapped address.
        wr(12'h7A0, 64'h7);
        rd(12'h7A0);
        chk("tsel_ignored", 128'(csr_rd_data), 128'(0));
        rd(12'h123);
        chk("unmapped_rd", 128'(csr_rd_data), 128'(0));

        // Sticky hit on trigger 3, then clear racing a new hit.
        trig_hit = 4'b1000;
        cycle();
        wr(12'h7A0, 64'd3);
        rd(12'h7A1);
        rd(12'h7A1);
        chk("hit3_sticky", 128'(csr_rd_data[20]), 128'(1));
        trig_hit = 4'b1000;
        wr(12'h7A1, 64'd0);
        rd(12'h7A1);
        chk("hit3_cleared", 128'(csr_rd_data[20]), 128'(0));

        // Same-cycle read and write returns the old value.
        csr_rd_valid = 1'b1;
        csr_rd_addr  = 12'h7A2;
        wr(12'h7A2, 64'h1234_5678_9ABC_DEF0);
        chk("rw_same_old", 128'(csr_rd_data), 128'(0));

        // Chain on triggers 0 and 1.
        wr(12'h7A0, 64'd0);
        wr(12'h7A1, 64'd1 << 11);
        wr(12'h7A0, 64'd1);
        dbg_mode = 1'b1;
        wr(12'h7A1, 64'd1 << 11);
        dbg_mode = 1'b0;
        rd(12'h7A1);
        chk("chain_t1_zero", 128'(csr_rd_data[11]), 128'(0));
        chk("chain_out", 128'(trigger_chain), 128'(CHAIN_EN ? 2'b01 : 2'b00));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            dbg_mode     = ($urandom_range(0, 7) == 0);
            csr_wr_valid = $urandom_range(0, 1) == 1;
            csr_wr_addr  = rand_addr();
            d = {$urandom, $urandom};
            if (csr_wr_addr == 12'h7A0 && $urandom_range(0, 3) != 0) d = 64'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d[17:12] = 6'($urandom_range(0, 2));
                d[10:7]  = 4'($urandom_range(0, 2));
            end
            csr_wr_data  = d;
            csr_rd_valid = $urandom_range(0, 1) == 1;
            csr_rd_addr  = rand_addr();
            trig_hit     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            cycle();
        end

        // Reset mid-operation with a read in flight.
        dbg_mode     = 1'b0;
        csr_rd_valid = 1'b1;
        csr_rd_addr  = 12'h7A1;
        #2;
        rst_l = 1'b0;
        model_reset();
        #1;
        chk("midrst_ack", 128'(csr_rd_ack), 128'(0));
        chk("midrst_data", 128'(csr_rd_data), 128'(0));
        check_pkt();
        @(posedge clk);
        #1;
        chk("midrst_ack_lost", 128'(csr_rd_ack), 128'(0));
        rst_l = 1'b1;
        csr_rd_valid = 1'b0;
        rd(12'h7A1);
        chk("post_rst_td1", 128'(csr_rd_data), 128'(64'h23E0_0000_0000_0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
